wb_rr_master_arb: RTL and testbench

WB_RR_MASTER_ARB -- requirements
Module: wb_rr_master_arb

---
 rtl/wb_rr_master_arb.sv | 160 ++++++++++++++++
 tb/tb_wb_rr_master_arb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_master_arb.sv
// Round-robin arbiter that lets four Wishbone masters share one slave port.
// It holds the grant for a whole burst and has a stall watchdog that aborts the cycle with a bus error.
module wb_rr_master_arb #(
    parameter int NUM_M       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_M-1:0]       m_wbd_cyc_i,
    input  logic [NUM_M-1:0]       m_wbd_stb_i,
    input  logic [NUM_M-1:0]       m_wbd_we_i,
    input  logic [NUM_M-1:0]       m_wbd_bry_i,
    input  logic [NUM_M-1:0][31:0] m_wbd_adr_i,
    input  logic [NUM_M-1:0][31:0] m_wbd_dat_i,
    input  logic [NUM_M-1:0][3:0]  m_wbd_sel_i,
    input  logic [NUM_M-1:0][9:0]  m_wbd_bl_i,
    output logic [31:0]            m_wbd_dat_o,
    output logic [NUM_M-1:0]       m_wbd_ack_o,
    output logic [NUM_M-1:0]       m_wbd_lack_o,
    output logic [NUM_M-1:0]       m_wbd_err_o,
    output logic [31:0]            s_wbd_adr_o,
    output logic [31:0]            s_wbd_dat_o,
    output logic [3:0]             s_wbd_sel_o,
    output logic [9:0]             s_wbd_bl_o,
    output logic                   s_wbd_bry_o,
    output logic                   s_wbd_we_o,
    output logic                   s_wbd_cyc_o,
    output logic                   s_wbd_stb_o,
    input  logic [31:0]            s_wbd_dat_i,
    input  logic                   s_wbd_ack_i,
    input  logic                   s_wbd_lack_i,
    input  logic                   s_wbd_err_i,
    output logic [NUM_M-1:0]       grant_o,
    output logic [1:0]             state_o
);

    localparam int IW   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int WD_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [NUM_M-1:0] grant;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   last_owner;
    logic [WD_W-1:0] wd;

    logic [NUM_M-1:0] req;
    logic [IW-1:0]    cand;
    logic [IW-1:0]    pick_idx;
    logic             pick_valid;
    logic             done;
    logic             timeout;

    assign req     = m_wbd_cyc_i & m_wbd_stb_i;
    assign grant_o = grant;
    assign state_o = state;

    // Search starts one past the previous owner so every master gets its turn.
    always_comb begin
        cand       = '0;
        pick_idx   = '0;
        pick_valid = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = IW'((int'(last_owner) + 1 + i) % NUM_M);
            if (!pick_valid && req[cand]) begin
                pick_idx   = cand;
                pick_valid = 1'b1;
            end
        end
    end

    assign done    = (s_wbd_ack_i & s_wbd_lack_i) | s_wbd_err_i | ~m_wbd_cyc_i[owner];
    assign timeout = (TIMEOUT_CYC != 0) && (wd == WD_W'(TIMEOUT_CYC));

    // A normal completion outranks a timeout that happens in the same cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_valid) state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (done)         state_nxt = ST_IDLE;
                else if (timeout) state_nxt = ST_ABORT;
            end
            ST_ABORT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            grant      <= '0;
            owner      <= '0;
            last_owner <= IW'(NUM_M - 1);
            wd         <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        owner <= pick_idx;
                        grant <= NUM_M'(1) << pick_idx;
                        wd    <= '0;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        grant      <= '0;
                        last_owner <= owner;
                    end else if (s_wbd_ack_i) begin
                        wd <= '0;
                    end else if (m_wbd_stb_i[owner] && wd != {WD_W{1'b1}}) begin
                        wd <= wd + 1'b1;
                    end
                end
                ST_ABORT: begin
                    grant      <= '0;
                    last_owner <= owner;
                end
                default: grant <= '0;
            endcase
        end
    end

    always_comb begin
        m_wbd_dat_o  = s_wbd_dat_i;
        m_wbd_ack_o  = '0;
        m_wbd_lack_o = '0;
        m_wbd_err_o  = '0;
        s_wbd_adr_o  = '0;
        s_wbd_dat_o  = '0;
        s_wbd_sel_o  = '0;
        s_wbd_bl_o   = '0;
        s_wbd_bry_o  = 1'b0;
        s_wbd_we_o   = 1'b0;
        s_wbd_cyc_o  = 1'b0;
        s_wbd_stb_o  = 1'b0;
        if (state == ST_BUSY) begin
            s_wbd_adr_o         = m_wbd_adr_i[owner];
            s_wbd_dat_o         = m_wbd_dat_i[owner];
            s_wbd_sel_o         = m_wbd_sel_i[owner];
            s_wbd_bl_o          = m_wbd_bl_i[owner];
            s_wbd_bry_o         = m_wbd_bry_i[owner];
            s_wbd_we_o          = m_wbd_we_i[owner];
            s_wbd_cyc_o         = m_wbd_cyc_i[owner];
            s_wbd_stb_o         = m_wbd_stb_i[owner];
            m_wbd_ack_o[owner]  = s_wbd_ack_i;
            m_wbd_lack_o[owner] = s_wbd_lack_i;
            m_wbd_err_o[owner]  = s_wbd_err_i;
        end else if (state == ST_ABORT) begin
            m_wbd_err_o[owner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_rr_master_arb.sv
// Directed bench for wb_rr_master_arb: round-robin order, burst hold, watchdog abort, reset and cyc drop.
module tb_wb_rr_master_arb;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [3:0]       m_wbd_cyc_i, m_wbd_stb_i, m_wbd_we_i, m_wbd_bry_i;
    logic [3:0][31:0] m_wbd_adr_i, m_wbd_dat_i;
    logic [3:0][3:0]  m_wbd_sel_i;
    logic [3:0][9:0]  m_wbd_bl_i;
    logic [31:0]      m_wbd_dat_o;
    logic [3:0]       m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o;
    logic [31:0]      s_wbd_adr_o, s_wbd_dat_o;
    logic [3:0]       s_wbd_sel_o;
    logic [9:0]       s_wbd_bl_o;
    logic             s_wbd_bry_o, s_wbd_we_o, s_wbd_cyc_o, s_wbd_stb_o;
    logic [31:0]      s_wbd_dat_i;
    logic             s_wbd_ack_i, s_wbd_lack_i, s_wbd_err_i;
    logic [3:0]       grant_o;
    logic [1:0]       state_o;

    int errors = 0;
    int checks = 0;

    wb_rr_master_arb #(.NUM_M(4), .TIMEOUT_CYC(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_wbd_cyc_i(m_wbd_cyc_i), .m_wbd_stb_i(m_wbd_stb_i),
        .m_wbd_we_i(m_wbd_we_i), .m_wbd_bry_i(m_wbd_bry_i),
        .m_wbd_adr_i(m_wbd_adr_i), .m_wbd_dat_i(m_wbd_dat_i),
        .m_wbd_sel_i(m_wbd_sel_i), .m_wbd_bl_i(m_wbd_bl_i),
        .m_wbd_dat_o(m_wbd_dat_o), .m_wbd_ack_o(m_wbd_ack_o),
        .m_wbd_lack_o(m_wbd_lack_o), .m_wbd_err_o(m_wbd_err_o),
        .s_wbd_adr_o(s_wbd_adr_o), .s_wbd_dat_o(s_wbd_dat_o),
        .s_wbd_sel_o(s_wbd_sel_o), .s_wbd_bl_o(s_wbd_bl_o),
        .s_wbd_bry_o(s_wbd_bry_o), .s_wbd_we_o(s_wbd_we_o),
        .s_wbd_cyc_o(s_wbd_cyc_o), .s_wbd_stb_o(s_wbd_stb_o),
        .s_wbd_dat_i(s_wbd_dat_i), .s_wbd_ack_i(s_wbd_ack_i),
        .s_wbd_lack_i(s_wbd_lack_i), .s_wbd_err_i(s_wbd_err_i),
        .grant_o(grant_o), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are checked 1-2 time units after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_master(input int m, input logic on);
        m_wbd_cyc_i[m] = on;
        m_wbd_stb_i[m] = on;
    endtask

    task automatic slave(input logic ack, input logic lack);
        s_wbd_ack_i  = ack;
        s_wbd_lack_i = lack;
        #1;
    endtask

    initial begin
        rst_i        = 1'b1;
        m_wbd_cyc_i  = '0;
        m_wbd_stb_i  = '0;
        m_wbd_we_i   = '0;
        m_wbd_bry_i  = '0;
        for (int m = 0; m < 4; m++) begin
            m_wbd_adr_i[m] = 32'h1000_0000 + 32'(m) * 32'h10;
            m_wbd_dat_i[m] = 32'hD000_0000 + 32'(m);
            m_wbd_sel_i[m] = 4'hF;
            m_wbd_bl_i[m]  = 10'd1;
        end
        s_wbd_dat_i  = 32'hCAFE_F00D;
        s_wbd_ack_i  = 1'b0;
        s_wbd_lack_i = 1'b0;
        s_wbd_err_i  = 1'b0;
        repeat (2) tick();
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_state", 32'(state_o), 32'h0);
        check("rst_cyc", 32'(s_wbd_cyc_o), 32'h0);
        check("rst_ack", 32'({m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o}), 32'h0);
        check("dat_bcast", m_wbd_dat_o, 32'hCAFE_F00D);

        // All four request together: grants 0,1,2,3 with one idle cycle between.
        #2 rst_i = 1'b0;
        for (int m = 0; m < 4; m++) set_master(m, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("rr_grant%0d", k), 32'(grant_o), 32'(4'b0001 << k));
            check($sformatf("rr_adr%0d", k), s_wbd_adr_o, 32'h1000_0000 + 32'(k) * 32'h10);
            check($sformatf("rr_dat%0d", k), s_wbd_dat_o, 32'hD000_0000 + 32'(k));
            slave(1'b1, 1'b1);
            check($sformatf("rr_ack%0d", k), 32'(m_wbd_ack_o), 32'(4'b0001 << k));
            tick();
            slave(1'b0, 1'b0);
            set_master(k, 1'b0);
            check($sformatf("rr_idle%0d", k), 32'({grant_o, 3'b000, s_wbd_cyc_o}), 32'h0);
        end

        // Master 2 burst of 4 held against a requesting master 0 (last owner is 3).
        m_wbd_bl_i[2] = 10'd4;
        set_master(2, 1'b1);
        tick();
        check("bst_grant", 32'(grant_o), 32'h4);
        set_master(0, 1'b1);
        for (int b = 0; b < 4; b++) begin
            slave(1'b1, b == 3);
            check($sformatf("bst_hold%0d", b), 32'(grant_o), 32'h4);
            check($sformatf("bst_ack%0d", b), 32'(m_wbd_ack_o), 32'h4);
            check($sformatf("bst_bl%0d", b), 32'(s_wbd_bl_o), 32'd4);
            tick();
        end
        slave(1'b0, 1'b0);
        set_master(2, 1'b0);
        check("bst_idle", 32'(grant_o), 32'h0);
        tick();
        check("bst_next", 32'(grant_o), 32'h1);
        slave(1'b1, 1'b1);
        tick();
        slave(1'b0, 1'b0);
        set_master(0, 1'b0);

        // Master 1 write never acked: abort after the watchdog reaches 16.
        m_wbd_we_i[1] = 1'b1;
        set_master(1, 1'b1);
        tick();
        check("to_grant", 32'(grant_o), 32'h2);
        check("to_we", 32'({s_wbd_we_o, s_wbd_stb_o}), 32'h3);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check($sformatf("to_wait%0d", i), 32'({state_o, m_wbd_err_o}), 32'h10);
        end
        tick();
        check("to_abort", 32'(state_o), 32'd2);
        check("to_err", 32'(m_wbd_err_o), 32'h2);
        check("to_cyc", 32'(s_wbd_cyc_o), 32'h0);
        set_master(1, 1'b0);
        m_wbd_we_i[1] = 1'b0;
        tick();
        check("to_idle", 32'({state_o, m_wbd_err_o, grant_o}), 32'h0);

        // Master 2: lack arrives in the very cycle the watchdog hits 16.
        set_master(2, 1'b1);
        m_wbd_bl_i[2] = 10'd1;
        tick();
        check("tl_grant", 32'(grant_o), 32'h4);
        repeat (16) tick();
        slave(1'b1, 1'b1);
        check("tl_lack", 32'(m_wbd_lack_o), 32'h4);
        check("tl_noerr", 32'(m_wbd_err_o), 32'h0);
        tick();
        slave(1'b0, 1'b0);
        set_master(2, 1'b0);
        check("tl_idle", 32'({state_o, m_wbd_err_o}), 32'h0);

        // Reset while master 3 owns the bus.
        set_master(3, 1'b1);
        tick();
        check("rb_grant", 32'(grant_o), 32'h8);
        check("rb_cyc", 32'(s_wbd_cyc_o), 32'h1);
        rst_i = 1'b1;
        slave(1'b1, 1'b1);
        check("rb_drop", 32'({s_wbd_cyc_o, s_wbd_stb_o}), 32'h0);
        check("rb_noack", 32'({m_wbd_ack_o, m_wbd_lack_o, m_wbd_err_o, grant_o}), 32'h0);
        slave(1'b0, 1'b0);
        rst_i = 1'b0;
        set_master(0, 1'b1);
        tick();
        check("rb_m0", 32'(grant_o), 32'h1);
        slave(1'b1, 1'b1);
        tick();
        slave(1'b0, 1'b0);
        set_master(0, 1'b0);
        tick();
        check("rb_m3", 32'(grant_o), 32'h8);
        slave(1'b1, 1'b1);
        tick();
        slave(1'b0, 1'b0);
        set_master(3, 1'b0);

        // Master 0 drops cyc mid-burst; pending master 1 is granted next.
        set_master(0, 1'b1);
        set_master(1, 1'b1);
        tick();
        check("cd_grant", 32'(grant_o), 32'h1);
        slave(1'b1, 1'b0);
        check("cd_beat", 32'({m_wbd_ack_o, m_wbd_lack_o}), 32'h10);
        tick();
        slave(1'b0, 1'b0);
        set_master(0, 1'b0);
        #1;
        check("cd_busy", 32'(state_o), 32'd1);
        tick();
        check("cd_idle", 32'({state_o, grant_o}), 32'h0);
        tick();
        check("cd_m1", 32'(grant_o), 32'h2);
        slave(1'b1, 1'b1);
        tick();
        slave(1'b0, 1'b0);
        set_master(1, 1'b0);
        tick();
        check("end_idle", 32'({state_o, grant_o}), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
